// File: rtl/sca_pkg.sv
// Shared types and helpers for the side-channel serial master.
package sca_pkg;

    localparam int MIN_HALF_DIV = 4;

    typedef enum logic [2:0] {
        IDLE,
        TRST,
        SHIFT_HI,
        SHIFT_LO,
        SETTLE,
        CAP,
        READ,
        DONE
    } sca_state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

endpackage

// File: rtl/sca_serial_master_if.sv
// Stimulus/response handshake bundle between host logic and the serial master.
interface sca_serial_master_if #(
    parameter int CFG_W = 16,
    parameter int OUT_W = 8
);
    logic [CFG_W-1:0] cfg_data;
    logic             cfg_trst;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [OUT_W-1:0] rsp_data;
    logic             rsp_valid;
    logic             rsp_ready;

    modport master (
        output cfg_data, cfg_trst, cfg_valid, rsp_ready,
        input  cfg_ready, rsp_data, rsp_valid
    );

    modport slave (
        input  cfg_data, cfg_trst, cfg_valid, rsp_ready,
        output cfg_ready, rsp_data, rsp_valid
    );
endinterface

// File: rtl/sca_clkgen_phase.sv
// Half-period timer shared by the reset, shift, capture and read phases.
module sca_clkgen_phase
    import sca_pkg::*;
#(
    parameter int HALF_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic phase_end
);
    localparam int HC_W = clog2(HALF_DIV);

    logic [HC_W-1:0] hc;

    // Held at zero while idle so every phase starts on a full half-period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hc <= '0;
        end else if (!run || phase_end) begin
            hc <= '0;
        end else begin
            hc <= hc + 1'b1;
        end
    end

    assign phase_end = run && (hc == HC_W'(HALF_DIV - 1));

endmodule

// File: rtl/sca_serial_master.sv
// Host-side driver: shifts a stimulus word into the target, captures and reads back its scan chain.
module sca_serial_master
    import sca_pkg::*;
#(
    parameter int CFG_W      = 16,
    parameter int OUT_W      = 8,
    parameter int HALF_DIV   = 4,
    parameter int SETTLE_CYC = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    sca_serial_master_if.slave  bus,
    output logic                sca_clk,
    output logic                sca_data,
    output logic                sca_rst_n,
    output logic                so_clk,
    output logic                so_en,
    input  logic                so_data,
    output logic                busy
);
    localparam int BIT_MAX = (CFG_W > OUT_W) ? CFG_W : OUT_W;
    localparam int BC_W    = clog2(BIT_MAX + 1);
    localparam int SC_W    = clog2(SETTLE_CYC + 1);

    if (HALF_DIV < MIN_HALF_DIV) begin : g_half_div_check
        $error("sca_serial_master: HALF_DIV below minimum");
    end
    if (SETTLE_CYC < 1) begin : g_settle_check
        $error("sca_serial_master: SETTLE_CYC must be at least 1");
    end

    sca_state_t       state;
    logic [CFG_W-2:0] sreg;   // bits still to send after the one on sca_data
    logic [OUT_W-1:0] rbuf;
    logic [BC_W-1:0]  bitcnt;
    logic [SC_W-1:0]  scnt;
    logic             lo_half;
    logic             so_meta;
    logic             so_sync;
    logic             run;
    logic             phase_end;
    logic             accept;

    assign accept = (state == IDLE) && bus.cfg_valid && bus.cfg_ready;
    assign run    = (state == TRST) || (state == SHIFT_HI) || (state == SHIFT_LO) ||
                    (state == CAP)  || (state == READ);

    sca_clkgen_phase #(.HALF_DIV(HALF_DIV)) u_phase (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .phase_end (phase_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            so_meta <= 1'b0;
            so_sync <= 1'b0;
        end else begin
            so_meta <= so_data;
            so_sync <= so_meta;
        end
    end

    // Payload registers are always reloaded before use, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            sreg <= bus.cfg_data[CFG_W-2:0];
        end else if (state == SHIFT_LO && phase_end) begin
            sreg <= sreg << 1;
        end
        if (state == READ && !lo_half && phase_end) begin
            rbuf <= {rbuf[OUT_W-2:0], so_sync};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            bus.cfg_ready <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            sca_clk       <= 1'b1;
            sca_data      <= 1'b0;
            sca_rst_n     <= 1'b1;
            so_clk        <= 1'b1;
            so_en         <= 1'b1;
            busy          <= 1'b0;
            bitcnt        <= '0;
            scnt          <= '0;
            lo_half       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        bus.cfg_ready <= 1'b0;
                        busy          <= 1'b1;
                        sca_data      <= bus.cfg_data[CFG_W-1];
                        if (bus.cfg_trst) begin
                            sca_rst_n <= 1'b0;
                            state     <= TRST;
                        end else begin
                            state <= SHIFT_HI;
                        end
                    end else begin
                        bus.cfg_ready <= 1'b1;
                    end
                end
                TRST: begin
                    if (phase_end) begin
                        lo_half <= !lo_half;
                        if (lo_half) begin
                            sca_rst_n <= 1'b1;
                            state     <= SHIFT_HI;
                        end
                    end
                end
                SHIFT_HI: begin
                    if (phase_end) begin
                        sca_clk <= 1'b0;
                        state   <= SHIFT_LO;
                    end
                end
                SHIFT_LO: begin
                    // Next bit goes out together with the rising edge, mid-way between falls.
                    if (phase_end) begin
                        sca_clk <= 1'b1;
                        if (bitcnt == BC_W'(CFG_W - 1)) begin
                            bitcnt <= '0;
                            state  <= SETTLE;
                        end else begin
                            bitcnt   <= bitcnt + 1'b1;
                            sca_data <= sreg[CFG_W-2];
                            state    <= SHIFT_HI;
                        end
                    end
                end
                SETTLE: begin
                    if (scnt == SC_W'(SETTLE_CYC - 1)) begin
                        scnt  <= '0;
                        so_en <= 1'b0;
                        state <= CAP;
                    end else begin
                        scnt <= scnt + 1'b1;
                    end
                end
                CAP: begin
                    if (phase_end) begin
                        lo_half <= !lo_half;
                        so_clk  <= lo_half;
                        if (lo_half) begin
                            so_en <= 1'b1;
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    if (phase_end) begin
                        if (lo_half) begin
                            so_clk  <= 1'b1;
                            lo_half <= 1'b0;
                        end else if (bitcnt == BC_W'(OUT_W - 1)) begin
                            bitcnt <= '0;
                            state  <= DONE;
                        end else begin
                            bitcnt  <= bitcnt + 1'b1;
                            so_clk  <= 1'b0;
                            lo_half <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // First DONE cycle publishes rbuf, which includes the final sample.
                    if (!bus.rsp_valid) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_data  <= rbuf;
                    end else if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.cfg_ready <= 1'b1;
                        busy          <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
